// File: rtl/geofence_feeder.sv
// Self-test source for the geofence engine: streams 7-word point records from a
// pattern ROM, then scores each valid/is_inside reply against the record's golden bit.
module geofence_feeder #(
    parameter int NUM_OBJ = 50,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [20:0]       rom_data,
    output logic [9:0]        X,
    output logic [9:0]        Y,
    input  logic              valid,
    input  logic              is_inside,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              timeout,
    output logic              done,
    output logic              all_pass
);

    localparam int OBJ_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_OBJ * 7 - 1);
    localparam logic [OBJ_W-1:0]  LAST_OBJ  = OBJ_W'(NUM_OBJ - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr, ptr_d, ptr_inc;
    logic [2:0]        pt_idx, pt_idx_d;
    logic [OBJ_W-1:0]  obj_idx, obj_idx_d;
    logic              golden, golden_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic [9:0]        x_d, y_d;
    logic [CNT_W-1:0]  pass_d, fail_d, err_d;
    logic              timeout_d, done_d, all_pass_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    assign rom_addr = ptr;

    // The pointer parks on the last ROM word so it never wraps to record 0.
    assign ptr_inc = (ptr == LAST_ADDR) ? ptr : ptr + 1'b1;

    assign all_pass_d = done && (pass_cnt == CNT_W'(NUM_OBJ)) &&
                        (fail_cnt == '0) && (err_cnt == '0);

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no
        // path through the case statement can leave one unassigned and infer a latch.
        state_d    = state;
        ptr_d      = ptr;
        pt_idx_d   = pt_idx;
        obj_idx_d  = obj_idx;
        golden_d   = golden;
        wait_cnt_d = wait_cnt;
        x_d        = X;
        y_d        = Y;
        pass_d     = pass_cnt;
        fail_d     = fail_cnt;
        err_d      = err_cnt;
        timeout_d  = timeout;
        done_d     = done;

        case (state)
            SEND: begin
                if (valid) err_d = sat_inc(err_cnt);
                x_d   = rom_data[19:10];
                y_d   = rom_data[9:0];
                ptr_d = ptr_inc;
                if (pt_idx == 3'd0) golden_d = rom_data[20];
                if (pt_idx == 3'd6) begin
                    state_d    = WAIT;
                    wait_cnt_d = '0;
                    pt_idx_d   = 3'd0;
                end else begin
                    pt_idx_d = pt_idx + 1'b1;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt + 1'b1;
                if (valid) begin
                    if (is_inside == golden) pass_d = sat_inc(pass_cnt);
                    else                     fail_d = sat_inc(fail_cnt);
                    if (obj_idx == LAST_OBJ) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        // Next object point goes out on this same edge: no idle bubble.
                        obj_idx_d = obj_idx + 1'b1;
                        x_d       = rom_data[19:10];
                        y_d       = rom_data[9:0];
                        golden_d  = rom_data[20];
                        ptr_d     = ptr_inc;
                        pt_idx_d  = 3'd1;
                        state_d   = SEND;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    fail_d    = sat_inc(fail_cnt);
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (valid) err_d = sat_inc(err_cnt);
            end
            default: state_d = SEND;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SEND;
            ptr      <= '0;
            pt_idx   <= '0;
            obj_idx  <= '0;
            golden   <= 1'b0;
            wait_cnt <= '0;
            X        <= '0;
            Y        <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err_cnt  <= '0;
            timeout  <= 1'b0;
            done     <= 1'b0;
            all_pass <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values computed above, independent of statement order.
            state    <= state_d;
            ptr      <= ptr_d;
            pt_idx   <= pt_idx_d;
            obj_idx  <= obj_idx_d;
            golden   <= golden_d;
            wait_cnt <= wait_cnt_d;
            X        <= x_d;
            Y        <= y_d;
            pass_cnt <= pass_d;
            fail_cnt <= fail_d;
            err_cnt  <= err_d;
            timeout  <= timeout_d;
            done     <= done_d;
            all_pass <= all_pass_d;
        end
    end

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed bench for geofence_feeder: ROM model plus a scripted engine that answers
// each object after a chosen delay; counters are tracked independently of the DUT.
module tb_geofence_feeder;

    localparam int NUM_OBJ = 50;
    localparam int ADDR_W  = 9;
    localparam int TIMEOUT = 4096;
    localparam int CNT_W   = 8;
    localparam int LAST    = NUM_OBJ * 7 - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] rom_addr;
    logic [20:0]       rom_data;
    logic [9:0]        X, Y;
    logic              valid, is_inside;
    logic [CNT_W-1:0]  pass_cnt, fail_cnt, err_cnt;
    logic              timeout, done, all_pass;

    logic [20:0] rom [0:NUM_OBJ*7-1];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_pass, exp_fail, exp_err;

    geofence_feeder #(
        .NUM_OBJ(NUM_OBJ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
        .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_cnt(err_cnt),
        .timeout(timeout), .done(done), .all_pass(all_pass)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    // Record 0 is obj(100,200,golden=1); later records follow simple strides.
    function automatic logic [9:0] px(input int o, input int w);
        return 10'((100 + o * 37 + w * 53) % 1024);
    endfunction
    function automatic logic [9:0] py(input int o, input int w);
        return 10'((200 + o * 29 + w * 71) % 1024);
    endfunction
    function automatic logic gold(input int o);
        return (o % 2) == 0;
    endfunction
    function automatic int addr_after(input int a);
        return (a > LAST) ? LAST : a;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        valid = 1'b0;
        is_inside = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        exp_err  = 0;
        #3;
        check("rst_x", X, 0);
        check("rst_y", Y, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_timeout", timeout, 0);
        check("rst_done", done, 0);
        check("rst_all_pass", all_pass, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Send words first_w..6 of object o; optional stray valid on word err_w.
    task automatic send_words(input int o, input int first_w, input int err_w);
        for (int w = first_w; w <= 6; w++) begin
            if (w == err_w) begin
                valid = 1'b1;
                is_inside = 1'b1;
            end
            tick();
            valid = 1'b0;
            is_inside = 1'b0;
            check("send_x", X, px(o, w));
            check("send_y", Y, py(o, w));
            check("send_addr", rom_addr, addr_after(o * 7 + w + 1));
            if (w == err_w) begin
                exp_err++;
                check("err_cnt", err_cnt, exp_err);
            end
        end
    endtask

    // Engine answers `res` on the wait_n-th WAIT cycle.
    task automatic respond(input int o, input int wait_n, input logic res);
        for (int i = 1; i < wait_n; i++) begin
            tick();
            check("wait_x", X, px(o, 6));
            check("wait_y", Y, py(o, 6));
            check("wait_addr", rom_addr, addr_after((o + 1) * 7));
        end
        valid = 1'b1;
        is_inside = res;
        tick();
        valid = 1'b0;
        is_inside = 1'b0;
        if (res == gold(o)) exp_pass++;
        else                exp_fail++;
        check("pass_cnt", pass_cnt, exp_pass);
        check("fail_cnt", fail_cnt, exp_fail);
        if (o < NUM_OBJ - 1) begin
            check("next_x", X, px(o + 1, 0));
            check("next_y", Y, py(o + 1, 0));
            check("next_addr", rom_addr, (o + 1) * 7 + 1);
            check("not_done", done, 0);
        end else begin
            check("done", done, 1);
            check("all_pass_lag", all_pass, 0);
            check("last_addr", rom_addr, LAST);
        end
    endtask

    initial begin
        for (int o = 0; o < NUM_OBJ; o++)
            for (int w = 0; w < 7; w++)
                rom[o * 7 + w] = {(w == 0) ? gold(o) : 1'(w % 2), px(o, w), py(o, w)};

        // Run 1: pass, mismatch with a stray valid in SEND, then the rest correct.
        apply_reset();
        send_words(0, 0, -1);
        respond(0, 3, 1'b1);
        send_words(1, 1, 3);
        respond(1, 2, 1'b1);
        for (int o = 2; o < NUM_OBJ; o++) begin
            send_words(o, 1, -1);
            respond(o, 1 + (o % 4), gold(o));
        end
        tick();
        check("r1_all_pass", all_pass, 0);
        check("r1_pass", pass_cnt, NUM_OBJ - 1);
        check("r1_fail", fail_cnt, 1);
        check("r1_err", err_cnt, 1);
        check("r1_frozen_x", X, px(NUM_OBJ - 1, 6));
        check("r1_frozen_addr", rom_addr, LAST);

        // Run 2: reset mid-WAIT at object 20, then a clean full run.
        apply_reset();
        for (int o = 0; o < 20; o++) begin
            send_words(o, (o == 0) ? 0 : 1, -1);
            respond(o, 1 + (o % 3), gold(o));
        end
        send_words(20, 1, -1);
        tick();
        apply_reset();
        for (int o = 0; o < NUM_OBJ; o++) begin
            send_words(o, (o == 0) ? 0 : 1, -1);
            respond(o, 1 + (o % 3), gold(o));
        end
        tick();
        check("r2_all_pass", all_pass, 1);
        check("r2_pass", pass_cnt, NUM_OBJ);
        check("r2_fail", fail_cnt, 0);
        check("r2_timeout", timeout, 0);

        // Run 3: engine never answers; stray valid while DONE.
        apply_reset();
        send_words(0, 0, -1);
        repeat (TIMEOUT - 1) tick();
        check("to_not_done", done, 0);
        check("to_not_timeout", timeout, 0);
        tick();
        check("to_timeout", timeout, 1);
        check("to_done", done, 1);
        check("to_fail", fail_cnt, 1);
        check("to_pass", pass_cnt, 0);
        check("to_x", X, px(0, 6));
        check("to_addr", rom_addr, 7);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("done_err", err_cnt, 1);
        tick();
        check("to_all_pass", all_pass, 0);
        check("to_frozen_y", Y, py(0, 6));
        check("to_frozen_addr", rom_addr, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
